// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload,
// per-period tick (usable as a clock enable) and valid/ready divisor loading.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic [WIDTH-1:0] count,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    // Reject a reset divisor that cannot produce a valid period or does not fit the counter
    if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > (longint'(1) << WIDTH) - longint'(1)) begin : g_bad_default
        $error("clk_div_prog: DEFAULT_DIV %0d outside 2..2^WIDTH-1", DEFAULT_DIV);
    end

    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;
    logic             div_err_q, div_err_d;

    logic [WIDTH-1:0] hi_c;
    logic [WIDTH-1:0] count_inc_c;
    logic             wrap_c;
    logic             accept_c;

    // Period bookkeeping: ceil-half high phase, wrap detection, handshake acceptance
    always_comb begin
        hi_c        = cur_div_q - (cur_div_q >> 1);
        count_inc_c = count_q + ONE;
        wrap_c      = (count_q == (cur_div_q - ONE));
        accept_c    = div_valid & ~pending_q;
    end

    // Next-state: counter/clk_out advance when enabled; divisor swaps only at a wrap
    always_comb begin
        count_d    = count_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        div_err_d  = 1'b0;

        if (enable) begin
            if (wrap_c) begin
                count_d   = '0;
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
                if (pending_q) begin
                    cur_div_d = pend_div_q;
                    pending_d = 1'b0;
                end
            end else begin
                count_d   = count_inc_c;
                clk_out_d = (count_inc_c < hi_c);
            end
        end

        // Acceptance only happens with nothing pending, so it never collides with a swap
        if (accept_c) begin
            if (div_value >= TWO) begin
                pend_div_d = div_value;
                pending_d  = 1'b1;
            end else begin
                div_err_d  = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset to the default-divisor state
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q    <= DEF_CNT;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= DEF_DIV;
            pending_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            div_err_q  <= div_err_d;
        end
    end

    // Output mapping; div_ready is decoded straight from the pending flop
    always_comb begin
        count     = count_q;
        cur_div   = cur_div_q;
        clk_out   = clk_out_q;
        tick      = tick_q;
        div_err   = div_err_q;
        div_ready = ~pending_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default period, bad loads, freeze, reload,
// reset with a pending load, and the extreme divisors 255 and 2.
module tb_clk_div_prog;

    logic       clk_in;
    logic       reset;
    logic       enable;
    logic [7:0] div_value;
    logic       div_valid;
    logic       div_ready;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;
    logic [7:0] count;
    logic       div_err;

    int checks = 0;
    int errors = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .div_value (div_value),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .count     (count),
        .div_err   (div_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge, then check every output against phase k of a period-p cycle
    task automatic edge_check(input int p, input int k, input bit rdy, input bit err);
        int hi;
        hi = p - p / 2;
        @(posedge clk_in);
        #1;
        chk("count",     32'(count),     32'(k));
        chk("tick",      32'(tick),      32'(k == 0));
        chk("clk_out",   32'(clk_out),   32'(k < hi));
        chk("cur_div",   32'(cur_div),   32'(p));
        chk("div_ready", 32'(div_ready), 32'(rdy));
        chk("div_err",   32'(div_err),   32'(err));
    endtask

    task automatic phases(input int p, input int first, input int last, input bit rdy);
        for (int k = first; k <= last; k++) edge_check(p, k, rdy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},   32'(count),     32'd9);
        chk({tag, "_cur_div"}, 32'(cur_div),   32'd10);
        chk({tag, "_clk_out"}, 32'(clk_out),   32'd0);
        chk({tag, "_tick"},    32'(tick),      32'd0);
        chk({tag, "_div_err"}, 32'(div_err),   32'd0);
        chk({tag, "_ready"},   32'(div_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        div_value = 8'd0;
        div_valid = 1'b0;
        #1;
        check_reset_state("rst_async");
        @(posedge clk_in);
        #1;
        check_reset_state("rst_held");
        reset  = 1'b0;
        enable = 1'b1;

        // Default divide-by-10: ticks at enabled edges 1, 11, 21; 5 high / 5 low
        for (int n = 0; n < 3; n++) phases(10, 0, 9, 1'b1);

        // Divisors 0 and 1 are rejected with a one-cycle div_err each
        phases(10, 0, 1, 1'b1);
        div_valid = 1'b1; div_value = 8'd0;
        edge_check(10, 2, 1'b1, 1'b1);
        div_valid = 1'b0;
        edge_check(10, 3, 1'b1, 1'b0);
        div_valid = 1'b1; div_value = 8'd1;
        edge_check(10, 4, 1'b1, 1'b1);
        div_valid = 1'b0;
        edge_check(10, 5, 1'b1, 1'b0);
        phases(10, 6, 9, 1'b1);

        // Freeze for 7 cycles at count 6: this period spans 17 clock cycles
        phases(10, 0, 6, 1'b1);
        enable = 1'b0;
        for (int n = 0; n < 7; n++) edge_check(10, 6, 1'b1, 1'b0);
        enable = 1'b1;
        phases(10, 7, 9, 1'b1);

        // Load 3 at count 4: busy until the wrap, then 2 high / 1 low
        phases(10, 0, 4, 1'b1);
        div_valid = 1'b1; div_value = 8'd3;
        edge_check(10, 5, 1'b0, 1'b0);
        div_valid = 1'b0;
        phases(10, 6, 9, 1'b0);
        for (int n = 0; n < 3; n++) phases(3, 0, 2, 1'b1);

        // Load 4 then reset mid-period: immediate return to reset state, load discarded
        div_valid = 1'b1; div_value = 8'd4;
        edge_check(3, 0, 1'b0, 1'b0);
        div_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid");
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        phases(10, 0, 9, 1'b1);
        edge_check(10, 0, 1'b1, 1'b0);

        // Load 255: 128 high / 127 low
        div_valid = 1'b1; div_value = 8'd255;
        edge_check(10, 1, 1'b0, 1'b0);
        div_valid = 1'b0;
        phases(10, 2, 9, 1'b0);
        phases(255, 0, 254, 1'b1);

        // Load 2 accepted on the wrap edge: deferred one full period, then toggles
        div_valid = 1'b1; div_value = 8'd2;
        edge_check(255, 0, 1'b0, 1'b0);
        div_valid = 1'b0;
        phases(255, 1, 254, 1'b0);
        for (int n = 0; n < 3; n++) phases(2, 0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
